// File: rtl/pwm_ctrl_pkg.sv
// Shared widths, limits, FSM encoding and duty-ramp helper for the PWM config sequencer.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package pwm_ctrl_pkg;

    localparam int N_W   = 26;
    localparam int D_W   = 14;
    localparam int DLY_W = 9;

    localparam logic [D_W-1:0]   D_MAX   = 14'd10000;
    localparam logic [DLY_W-1:0] DLY_MAX = 9'd359;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_PEND = 2'd2;
    localparam logic [1:0] ST_RAMP = 2'd3;

    typedef struct packed {
        logic [N_W-1:0]   n;
        logic [D_W-1:0]   d;
        logic [DLY_W-1:0] dly;
    } pwm_cfg_t;

    // One duty step toward tgt; lands exactly on tgt once within one step of it.
    function automatic logic [D_W-1:0] ramp_next(input logic [D_W-1:0] cur,
                                                 input logic [D_W-1:0] tgt,
                                                 input logic [D_W-1:0] step);
        logic signed [D_W:0] diff;
        logic signed [D_W:0] sstep;
        diff  = signed'({1'b0, tgt}) - signed'({1'b0, cur});
        sstep = signed'({1'b0, step});
        if (diff > sstep) begin
            return cur + step;
        end else if (diff < -sstep) begin
            return cur - step;
        end else begin
            return tgt;
        end
    endfunction

endpackage

// File: rtl/pwm_period_tracker.sv
// Mirrors the generator's 0..n+1 counter and flags the last clock of each period.
// Latency: tick is combinational from the count register; count restarts at 0 the cycle after clr drops.
// Backpressure: none; free-running while clr is low.
module pwm_period_tracker
    import pwm_ctrl_pkg::*;
(
    input  logic           clk,
    input  logic           aclr_n,
    input  logic           clr,
    input  logic [N_W-1:0] n,
    output logic           tick
);

    logic [N_W:0] r_cnt;
    logic [N_W:0] w_last;
    logic         w_wrap;

    // 27-bit compare so n = 2^26-1 still wraps at 2^26.
    assign w_last = {1'b0, n} + (N_W+1)'(1);
    assign w_wrap = (r_cnt == w_last);
    assign tick   = !clr && w_wrap;

    always_ff @(posedge clk or negedge aclr_n) begin
        if (!aclr_n) begin
            r_cnt <= '0;
        end else if (clr || w_wrap) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + (N_W+1)'(1);
        end
    end

endmodule

// File: rtl/pwm_cfg_sequencer.sv
// Range-checks host PWM settings and applies them to the generator only at period boundaries (PWM_DUTY_RAMP_EN adds a per-period duty ramp).
// Latency: accepted setting reaches pwm_* next edge in IDLE, at the period_tick edge in RUN; cfg_err one cycle after a rejected transfer.
// Backpressure: cfg_ready low while a setting is pending or a ramp is in progress, and during reset.
module pwm_cfg_sequencer
    import pwm_ctrl_pkg::*;
#(
    parameter logic [N_W-1:0] MIN_N = 26'd2,
    parameter logic [N_W-1:0] DEF_N = 26'd998
`ifdef PWM_DUTY_RAMP_EN
    ,
    parameter int unsigned    RAMP_STEP = 100
`endif
) (
    input  logic             clk,
    input  logic             aclr_n,
    input  logic             enable,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [N_W-1:0]   cfg_n,
    input  logic [D_W-1:0]   cfg_d,
    input  logic [DLY_W-1:0] cfg_delay,
    output logic             cfg_err,
    output logic [N_W-1:0]   pwm_n,
    output logic [D_W-1:0]   pwm_d,
    output logic [DLY_W-1:0] pwm_delay,
    output logic             pwm_sclear,
    output logic             period_tick,
    output logic             busy
);

`ifdef PWM_DUTY_RAMP_EN
    localparam logic [D_W-1:0] STEP = D_W'(RAMP_STEP);
`endif

    logic [1:0] r_state;
    logic [1:0] w_nxt_state;
    pwm_cfg_t   r_pwm;
    pwm_cfg_t   w_nxt_pwm;
    pwm_cfg_t   r_shadow;
    pwm_cfg_t   w_nxt_shadow;
    pwm_cfg_t   w_cfg;
    logic       r_sclear;
    logic       r_cfg_ready;
    logic       r_cfg_err;
    logic       w_xfer;
    logic       w_bad;
    logic       w_acc;
    logic       w_tick;

    assign w_cfg  = '{n: cfg_n, d: cfg_d, dly: cfg_delay};
    assign w_xfer = cfg_valid && r_cfg_ready;
    assign w_bad  = (cfg_n < MIN_N) || (cfg_d > D_MAX) || (cfg_delay > DLY_MAX);
    assign w_acc  = w_xfer && !w_bad;

    pwm_period_tracker u_tracker (
        .clk    (clk),
        .aclr_n (aclr_n),
        .clr    (r_sclear),
        .n      (r_pwm.n),
        .tick   (w_tick)
    );

    always_comb begin
        w_nxt_state  = r_state;
        w_nxt_pwm    = r_pwm;
        w_nxt_shadow = r_shadow;
        if (!enable) begin
            // Dropping enable never loses a setting: pending or ramping targets land now.
            w_nxt_state = ST_IDLE;
            case (r_state)
                ST_PEND: w_nxt_pwm   = r_shadow;
                ST_RAMP: w_nxt_pwm.d = r_shadow.d;
                default: if (w_acc) w_nxt_pwm = w_cfg;
            endcase
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_acc) w_nxt_pwm = w_cfg;
                    w_nxt_state = ST_RUN;
                end
                ST_RUN: begin
                    if (w_acc) begin
                        w_nxt_shadow = w_cfg;
                        w_nxt_state  = ST_PEND;
                    end
                end
                ST_PEND: begin
                    if (w_tick) begin
                        w_nxt_pwm   = r_shadow;
                        w_nxt_state = ST_RUN;
`ifdef PWM_DUTY_RAMP_EN
                        w_nxt_pwm.d = ramp_next(r_pwm.d, r_shadow.d, STEP);
                        if (w_nxt_pwm.d != r_shadow.d) w_nxt_state = ST_RAMP;
`endif
                    end
                end
`ifdef PWM_DUTY_RAMP_EN
                ST_RAMP: begin
                    if (w_tick) begin
                        w_nxt_pwm.d = ramp_next(r_pwm.d, r_shadow.d, STEP);
                        if (w_nxt_pwm.d == r_shadow.d) w_nxt_state = ST_RUN;
                    end
                end
`endif
                default: w_nxt_state = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge aclr_n) begin
        if (!aclr_n) begin
            r_state     <= ST_IDLE;
            r_pwm       <= '{n: DEF_N, d: '0, dly: '0};
            r_shadow    <= '0;
            r_sclear    <= 1'b1;
            r_cfg_ready <= 1'b0;
            r_cfg_err   <= 1'b0;
        end else begin
            r_state     <= w_nxt_state;
            r_pwm       <= w_nxt_pwm;
            r_shadow    <= w_nxt_shadow;
            r_sclear    <= (w_nxt_state == ST_IDLE);
            r_cfg_ready <= (w_nxt_state == ST_IDLE) || (w_nxt_state == ST_RUN);
            r_cfg_err   <= w_xfer && w_bad;
        end
    end

    assign cfg_ready   = r_cfg_ready;
    assign cfg_err     = r_cfg_err;
    assign pwm_n       = r_pwm.n;
    assign pwm_d       = r_pwm.d;
    assign pwm_delay   = r_pwm.dly;
    assign pwm_sclear  = r_sclear;
    assign period_tick = w_tick;
    assign busy        = (r_state == ST_PEND) || (r_state == ST_RAMP);

endmodule

// File: tb/tb_pwm_cfg_sequencer.sv
// Scoreboard bench for pwm_cfg_sequencer: stimulus pushes expected pwm_* updates and cfg_err pulses,
// a negedge monitor pops and compares each one as the DUT presents it.
module tb_pwm_cfg_sequencer;

    logic        clk = 1'b0;
    logic        aclr_n = 1'b1;
    logic        enable = 1'b0;
    logic        cfg_valid = 1'b0;
    logic [25:0] cfg_n = '0;
    logic [13:0] cfg_d = '0;
    logic [8:0]  cfg_delay = '0;
    logic        cfg_ready, cfg_err, pwm_sclear, period_tick, busy;
    logic [25:0] pwm_n;
    logic [13:0] pwm_d;
    logic [8:0]  pwm_delay;

    pwm_cfg_sequencer dut (
        .clk         (clk),
        .aclr_n      (aclr_n),
        .enable      (enable),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .cfg_n       (cfg_n),
        .cfg_d       (cfg_d),
        .cfg_delay   (cfg_delay),
        .cfg_err     (cfg_err),
        .pwm_n       (pwm_n),
        .pwm_d       (pwm_d),
        .pwm_delay   (pwm_delay),
        .pwm_sclear  (pwm_sclear),
        .period_tick (period_tick),
        .busy        (busy)
    );

    initial forever #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        bit          err;
        logic [25:0] n;
        logic [13:0] d;
        logic [8:0]  dly;
        bit          tk;
    } ev_t;

    ev_t exp_q[$];
    int  n_cmp = 0;
    int  n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic exp_apply(input logic [25:0] n, input logic [13:0] d, input logic [8:0] dly, input bit tk);
        ev_t e;
        e.err = 1'b0; e.n = n; e.d = d; e.dly = dly; e.tk = tk;
        exp_q.push_back(e);
    endtask

    task automatic exp_err(input logic [25:0] n, input logic [13:0] d, input logic [8:0] dly);
        ev_t e;
        e.err = 1'b1; e.n = n; e.d = d; e.dly = dly; e.tk = 1'b0;
        exp_q.push_back(e);
    endtask

    task automatic pop_cmp(input bit err, input bit tk);
        ev_t e;
        n_cmp++;
        if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL sb_unexpected: got err=%0b n=%0d d=%0d dly=%0d, want no event (t=%0t)",
                     err, pwm_n, pwm_d, pwm_delay, $time);
        end else begin
            e = exp_q.pop_front();
            if (e.err != err || e.n !== pwm_n || e.d !== pwm_d || e.dly !== pwm_delay ||
                (!err && e.tk != tk)) begin
                n_bad++;
                $display("FAIL sb_event: got err=%0b n=%0d d=%0d dly=%0d tick=%0b, want err=%0b n=%0d d=%0d dly=%0d tick=%0b (t=%0t)",
                         err, pwm_n, pwm_d, pwm_delay, tk, e.err, e.n, e.d, e.dly, e.tk, $time);
            end
        end
    endtask

    // Monitor: an apply is any change of pwm_*, tagged with whether the previous cycle was a tick.
    logic [25:0] pn;
    logic [13:0] pd;
    logic [8:0]  pdl;
    bit          ptk;
    always @(negedge clk) begin
        if (!aclr_n) begin
            pn = pwm_n; pd = pwm_d; pdl = pwm_delay; ptk = 1'b0;
        end else begin
            if (cfg_err === 1'b1) pop_cmp(1'b1, 1'b0);
            if (pwm_n !== pn || pwm_d !== pd || pwm_delay !== pdl) pop_cmp(1'b0, ptk);
            pn = pwm_n; pd = pwm_d; pdl = pwm_delay; ptk = (period_tick === 1'b1);
        end
    end

    task automatic send(input logic [25:0] n, input logic [13:0] d, input logic [8:0] dly);
        int k = 0;
        cfg_n = n; cfg_d = d; cfg_delay = dly; cfg_valid = 1'b1;
        while (cfg_ready !== 1'b1 && k < 500) begin
            @(posedge clk); #1; k++;
        end
        chk("send_ready", cfg_ready, 1);
        @(posedge clk); #1;
        cfg_valid = 1'b0;
    endtask

    task automatic wait_tick(output int c);
        int k = 0;
        do begin
            @(negedge clk); k++;
        end while (period_tick !== 1'b1 && k < 1000);
        chk("tick_seen", period_tick, 1);
        c = cyc;
    endtask

    task automatic wait_idle();
        int k = 0;
        while (busy !== 1'b0 && k < 20000) begin
            @(posedge clk); #1; k++;
        end
        chk("busy_clear", busy, 0);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_pwm_n"}, pwm_n, 998);
        chk({tag, "_pwm_d"}, pwm_d, 0);
        chk({tag, "_pwm_delay"}, pwm_delay, 0);
        chk({tag, "_sclear"}, pwm_sclear, 1);
        chk({tag, "_cfg_ready"}, cfg_ready, 0);
        chk({tag, "_cfg_err"}, cfg_err, 0);
        chk({tag, "_tick"}, period_tick, 0);
        chk({tag, "_busy"}, busy, 0);
    endtask

    initial begin
        int t1, t2;
        #1 aclr_n = 1'b0;
        #2 chk_reset_vals("reset");
        @(posedge clk); @(posedge clk); #1;
        aclr_n = 1'b1;
        chk("ready_before_edge", cfg_ready, 0);
        @(posedge clk); #1;
        chk("ready_after_release", cfg_ready, 1);

        // Test 1: setting taken in IDLE goes straight to pwm_*, generator stays cleared
        exp_apply(26'd98, 14'd2500, 9'd0, 1'b0);
        send(26'd98, 14'd2500, 9'd0);
        chk("t1_pwm_d", pwm_d, 2500);
        chk("t1_sclear", pwm_sclear, 1);

        // Test 2: run at N=98, change duty mid-period
        enable = 1'b1;
        wait_tick(t1);
        wait_tick(t2);
        chk("t2_period", t2 - t1, 100);
        repeat (30) @(posedge clk);
        #1;
`ifdef PWM_DUTY_RAMP_EN
        for (int d = 2600; d <= 7500; d += 100) exp_apply(26'd98, 14'(d), 9'd0, 1'b1);
`else
        exp_apply(26'd98, 14'd7500, 9'd0, 1'b1);
`endif
        send(26'd98, 14'd7500, 9'd0);
        chk("t2_busy", busy, 1);
        chk("t2_ready_low", cfg_ready, 0);
        wait_idle();
        chk("t2_ready_back", cfg_ready, 1);
        wait_tick(t1);
        wait_tick(t2);
        chk("t2_period_after", t2 - t1, 100);

        // Test 3: out-of-range settings are rejected one pulse each
        exp_err(26'd98, 14'd7500, 9'd0);
        send(26'd98, 14'd10001, 9'd0);
        chk("t3_ready_d", cfg_ready, 1);
        exp_err(26'd98, 14'd7500, 9'd0);
        send(26'd98, 14'd7500, 9'd360);
        chk("t3_ready_dly", cfg_ready, 1);
        exp_err(26'd98, 14'd7500, 9'd0);
        send(26'd1, 14'd7500, 9'd0);
        chk("t3_ready_n", cfg_ready, 1);
        chk("t3_busy", busy, 0);

        // Test 4: enable drops while a setting is pending
        wait_tick(t1);
        repeat (20) @(posedge clk);
        #1;
        exp_apply(26'd50, 14'd1234, 9'd90, 1'b0);
        send(26'd50, 14'd1234, 9'd90);
        chk("t4_pend_busy", busy, 1);
        enable = 1'b0;
        @(posedge clk); #1;
        chk("t4_sclear", pwm_sclear, 1);
        chk("t4_ready", cfg_ready, 1);
        chk("t4_busy", busy, 0);
        chk("t4_pwm_n", pwm_n, 50);

        // Boundary-legal values, then period shrinks to MIN_N+2
        enable = 1'b1;
        repeat (5) @(posedge clk);
        #1;
`ifdef PWM_DUTY_RAMP_EN
        for (int d = 1334; d < 10000; d += 100) exp_apply(26'd2, 14'(d), 9'd359, 1'b1);
`endif
        exp_apply(26'd2, 14'd10000, 9'd359, 1'b1);
        send(26'd2, 14'd10000, 9'd359);
        wait_idle();
        wait_tick(t1);
        wait_tick(t2);
        chk("t5_period_min", t2 - t1, 4);

        // enable falls on the same edge as a transfer: still accepted, applied in IDLE
        wait_tick(t1);
        @(posedge clk); #1;
        chk("sim_ready", cfg_ready, 1);
        exp_apply(26'd20, 14'd5000, 9'd45, 1'b0);
        cfg_n = 26'd20; cfg_d = 14'd5000; cfg_delay = 9'd45; cfg_valid = 1'b1;
        enable = 1'b0;
        @(posedge clk); #1;
        cfg_valid = 1'b0;
        chk("sim_sclear", pwm_sclear, 1);
        chk("sim_busy", busy, 0);

        // IDLE: largest N accepted, N below MIN_N rejected
        exp_apply(26'h3FFFFFF, 14'd0, 9'd0, 1'b0);
        send(26'h3FFFFFF, 14'd0, 9'd0);
        exp_err(26'h3FFFFFF, 14'd0, 9'd0);
        send(26'd1, 14'd0, 9'd0);
        exp_apply(26'd8, 14'd0, 9'd0, 1'b0);
        send(26'd8, 14'd0, 9'd0);

        // Duty 0 -> 350, then async reset mid-period (mid-ramp when the ramp is built in)
        enable = 1'b1;
        repeat (3) @(posedge clk);
        #1;
`ifdef PWM_DUTY_RAMP_EN
        exp_apply(26'd8, 14'd100, 9'd0, 1'b1);
        exp_apply(26'd8, 14'd200, 9'd0, 1'b1);
`else
        exp_apply(26'd8, 14'd350, 9'd0, 1'b1);
`endif
        send(26'd8, 14'd350, 9'd0);
        wait_tick(t1);
        wait_tick(t2);
        repeat (3) @(posedge clk);
        #3;
`ifdef PWM_DUTY_RAMP_EN
        chk("t6_busy_ramp", busy, 1);
`else
        chk("t6_busy_run", busy, 0);
`endif
        chk("t6_sclear_run", pwm_sclear, 0);
        aclr_n = 1'b0;
        #1 chk_reset_vals("areset");
        @(negedge clk);
        @(posedge clk); #1;
        aclr_n = 1'b1;
        @(posedge clk); #1;
        chk("ready_after_rerelease", cfg_ready, 1);

        chk("scoreboard_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: got timeout at t=%0t, want completion", $time);
        $fatal(1, "watchdog");
    end

endmodule
